// File: rtl/btn_arb_pkg.sv
// rtl/btn_arb_pkg.sv - shared types and constants for the button interrupt arbiter
// Purpose: FSM state encoding and service counter width used by btn_intr_arbiter.
// Ports: none (package).
package btn_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  // Shared by the ACK timeout and the post-ACK gap; cleared on every state entry.
  localparam int CNT_W = 8;

endpackage

// File: rtl/btn_rr_pick.sv
// rtl/btn_rr_pick.sv - combinational masked priority encoder with a movable start index
// Purpose: picks the first set request at or above start, wrapping to the lowest set
//          request when nothing at or above start is set. start=0 gives fixed priority.
// Ports:
//   req   in  N   request vector
//   start in  IW  index where the search begins
//   valid out 1   any request set
//   idx   out IW  chosen request index (0 when valid=0)
module btn_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic          hi_found;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;

  // Scanning downwards leaves the lowest matching index in each candidate.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IW'(i);
        if (i >= int'(start)) begin
          hi_idx   = IW'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  assign valid = |req;
  assign idx   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/btn_intr_arbiter.sv
// rtl/btn_intr_arbiter.sv - holds button presses as pending and serves them on one interrupt line
// Purpose: captures one-shot press pulses, arbitrates among pending presses, raises INTR
//          with the winning BTN_ID until the CPU acknowledges (or a timeout fires), then
//          forces INTR low for GAP_CLKS cycles so the CPU sees a fresh edge.
// Configuration: define BTN_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default
//                build uses fixed priority (lowest index wins).
// Ports:
//   CLK        in  1      system clock
//   RST        in  1      synchronous active-high reset
//   BTN_PULSE  in  N_BTN  one-shot press pulses
//   INTR_ACK   in  1      CPU acknowledge strobe (only honoured while waiting for ACK)
//   OVR_CLR    in  1      clears OVERRUN and TIMEOUT
//   INTR       out 1      interrupt request
//   BTN_ID     out log2N  button being serviced; holds its last value when idle
//   PENDING    out N_BTN  pending press vector
//   OVERRUN    out N_BTN  sticky: press arrived while the same bit was already pending
//   TIMEOUT    out 1      sticky: an ACK timeout dropped a press
module btn_intr_arbiter
  import btn_arb_pkg::*;
#(
  parameter int               N_BTN       = 4,
  parameter int               GAP_CLKS    = 8,
  parameter logic [CNT_W-1:0] ACK_TIMEOUT = 8'hFF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_BTN-1:0]           BTN_PULSE,
  input  logic                       INTR_ACK,
  input  logic                       OVR_CLR,
  output logic                       INTR,
  output logic [$clog2(N_BTN)-1:0]   BTN_ID,
  output logic [N_BTN-1:0]           PENDING,
  output logic [N_BTN-1:0]           OVERRUN,
  output logic                       TIMEOUT
);

  localparam int IW = $clog2(N_BTN);

  // The IDLE arbitration cycle is part of the low gap, so ST_GAP itself lasts
  // GAP_CLKS-1 cycles (at least one). INTR stays low GAP_CLKS cycles before a
  // back-to-back request, giving GAP_CLKS+2 cycles between rising edges.
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CLKS <= 2) ? '0 : CNT_W'(GAP_CLKS - 2);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [N_BTN-1:0] pending_q;
  logic [N_BTN-1:0] overrun_q;
  logic [N_BTN-1:0] clr_vec;
  logic [N_BTN-1:0] ovr_set;
  logic             timeout_q;
  logic             to_set;
  logic             grant;
  logic [IW-1:0]    btn_id_q;
  logic [IW-1:0]    start_idx;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;

`ifdef BTN_ARB_ROUND_ROBIN_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BTN - 1);

  logic [IW-1:0] last_q;

  // Resetting to the top index makes the first search start at index 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q <= LAST_IDX;
    end else if (grant) begin
      last_q <= pick_idx;
    end
  end

  assign start_idx = (last_q == LAST_IDX) ? '0 : last_q + IW'(1);
`else
  assign start_idx = '0;
`endif

  btn_rr_pick #(
    .N  (N_BTN),
    .IW (IW)
  ) u_pick (
    .req   (pending_q),
    .start (start_idx),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    to_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ASSERT;
          grant   = 1'b1;
        end
      end
      ST_ASSERT: begin
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (INTR_ACK) begin
          state_d = ST_GAP;
        end else if ((ACK_TIMEOUT != '0) && (cnt_q == ACK_TIMEOUT)) begin
          // The press is dropped, not re-queued.
          state_d = ST_GAP;
          to_set  = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    INTR = 1'b0;
    case (state_q)
      ST_ASSERT:   INTR = 1'b1;
      ST_WAIT_ACK: INTR = 1'b1;
      default:     INTR = 1'b0;
    endcase
  end

  always_comb begin
    clr_vec = '0;
    if (grant) begin
      clr_vec[pick_idx] = 1'b1;
    end
  end

  // A pulse landing on the grant clear of the same bit re-arms pending without an overrun.
  assign ovr_set = BTN_PULSE & pending_q & ~clr_vec;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_q <= '0;
      overrun_q <= '0;
      timeout_q <= 1'b0;
      btn_id_q  <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_vec) | BTN_PULSE;
      overrun_q <= (OVR_CLR ? '0 : overrun_q) | ovr_set;
      timeout_q <= (timeout_q & ~OVR_CLR) | to_set;
      if (grant) begin
        btn_id_q <= pick_idx;
      end
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if ((state_q == ST_WAIT_ACK) || (state_q == ST_GAP)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign BTN_ID  = btn_id_q;
  assign PENDING = pending_q;
  assign OVERRUN = overrun_q;
  assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_btn_intr_arbiter.sv
// tb/tb_btn_intr_arbiter.sv - self-checking bench for btn_intr_arbiter against a behavioural model
module tb_btn_intr_arbiter;

  localparam int N    = 4;
  localparam int GAP  = 8;
  localparam int TMO  = 16;
  localparam int GAPN = (GAP <= 1) ? 1 : GAP - 1;

  logic         CLK       = 1'b0;
  logic         RST       = 1'b1;
  logic [N-1:0] BTN_PULSE = '0;
  logic         INTR_ACK  = 1'b0;
  logic         OVR_CLR   = 1'b0;
  logic         INTR;
  logic [1:0]   BTN_ID;
  logic [N-1:0] PENDING;
  logic [N-1:0] OVERRUN;
  logic         TIMEOUT;

  btn_intr_arbiter #(
    .N_BTN       (N),
    .GAP_CLKS    (GAP),
    .ACK_TIMEOUT (8'(TMO))
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BTN_PULSE (BTN_PULSE),
    .INTR_ACK  (INTR_ACK),
    .OVR_CLR   (OVR_CLR),
    .INTR      (INTR),
    .BTN_ID    (BTN_ID),
    .PENDING   (PENDING),
    .OVERRUN   (OVERRUN),
    .TIMEOUT   (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int last_rise = 0;
  bit have_rise = 1'b0;
  bit prev_intr = 1'b0;

  // Model: an interrupt episode has an age (edges since INTR rose) and, once it
  // ends, a hold of GAPN edges during which nothing may be granted.
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_ovr  = '0;
  bit           m_to   = 1'b0;
  bit           m_intr = 1'b0;
  int           m_id   = 0;
  int           m_age  = 0;
  int           m_hold = 0;
  int           m_last = N - 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] clr;
    bit           to_hit;
    int           s;
    int           w;
    clr    = '0;
    to_hit = 1'b0;
    if (RST) begin
      m_pend = '0; m_ovr = '0; m_to = 1'b0; m_intr = 1'b0;
      m_id = 0; m_age = 0; m_hold = 0; m_last = N - 1;
      return;
    end
    if (m_intr) begin
      if (m_age >= 1 && INTR_ACK) begin
        m_intr = 1'b0;
        m_hold = GAPN;
      end else if (m_age >= 1 && TMO != 0 && m_age - 1 == TMO) begin
        m_intr = 1'b0;
        m_hold = GAPN;
        to_hit = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_pend != '0) begin
`ifdef BTN_ARB_ROUND_ROBIN_EN
      s = (m_last + 1) % N;
`else
      s = 0;
`endif
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && m_pend[(s + k) % N]) w = (s + k) % N;
      end
      clr[w] = 1'b1;
      m_intr = 1'b1;
      m_age  = 0;
      m_id   = w;
      m_last = w;
    end
    m_ovr  = (OVR_CLR ? '0 : m_ovr) | (BTN_PULSE & m_pend & ~clr);
    m_to   = (m_to && !OVR_CLR) || to_hit;
    m_pend = (m_pend & ~clr) | BTN_PULSE;
  endtask

  task automatic compare_all();
    check("intr", INTR, m_intr);
    check("btn_id", BTN_ID, m_id);
    check("pending", PENDING, m_pend);
    check("overrun", OVERRUN, m_ovr);
    check("timeout", TIMEOUT, m_to);
    if (INTR === 1'b1 && !prev_intr) begin
      if (have_rise) check("rise_spacing", 32'((cyc - last_rise) >= GAP + 2), 1);
      have_rise = 1'b1;
      last_rise = cyc;
    end
    prev_intr = (INTR === 1'b1);
    if (RST) have_rise = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic ack();
    INTR_ACK = 1'b1;
    step();
    INTR_ACK = 1'b0;
  endtask

  task automatic wait_intr(input string tag, output int rise);
    int n;
    n = 0;
    while (INTR !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check({tag, "_seen"}, INTR, 1);
    rise = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r1;
    int r2;
    int hi;
    int exp_id;

    // Reset
    RST = 1'b1;
    step();
    step();
    check("rst_intr", INTR, 0);
    check("rst_pend", PENDING, 0);
    check("rst_id", BTN_ID, 0);
    RST = 1'b0;
    step();

    // Single press: INTR two cycles after the pulse, low gap after ACK
    BTN_PULSE = 4'b0100;
    step();
    BTN_PULSE = '0;
    step();
    check("single_intr", INTR, 1);
    check("single_id", BTN_ID, 2);
    repeat (4) step();
    ack();
    check("single_drop", INTR, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      check("single_gap_low", INTR, 0);
    end
    check("single_pend", PENDING, 0);

    // Simultaneous presses: lower index first, rising edges GAP+2 apart
    BTN_PULSE = 4'b1010;
    step();
    BTN_PULSE = '0;
    wait_intr("sim1", r1);
    check("sim1_id", BTN_ID, 1);
    step();
    ack();
    wait_intr("sim2", r2);
    check("sim2_id", BTN_ID, 3);
    check("sim_spacing", r2 - r1, GAP + 2);
    step();
    ack();
    repeat (10) step();

    // Overrun while bit 1 is being serviced
    BTN_PULSE = 4'b0010;
    step();
    BTN_PULSE = '0;
    wait_intr("ovr", r1);
    step();
    BTN_PULSE = 4'b0001;
    step();
    step();
    BTN_PULSE = '0;
    check("ovr_set", OVERRUN, 4'b0001);
    OVR_CLR = 1'b1;
    step();
    OVR_CLR = 1'b0;
    check("ovr_clr", OVERRUN, 0);
    OVR_CLR   = 1'b1;
    BTN_PULSE = 4'b0001;
    step();
    OVR_CLR   = 1'b0;
    BTN_PULSE = '0;
    check("ovr_set_wins", OVERRUN, 4'b0001);
    ack();
    wait_intr("ovr_b0", r1);
    check("ovr_b0_id", BTN_ID, 0);
    step();
    ack();
    OVR_CLR = 1'b1;
    step();
    OVR_CLR = 1'b0;
    repeat (10) step();

    // ACK timeout: INTR high for ASSERT plus TMO+1 wait cycles
    BTN_PULSE = 4'b0100;
    step();
    BTN_PULSE = '0;
    wait_intr("to", r1);
    hi = 0;
    while (INTR === 1'b1 && hi < 40) begin
      hi++;
      step();
    end
    check("to_high_cycles", hi, TMO + 2);
    check("to_flag", TIMEOUT, 1);
    check("to_intr", INTR, 0);
    repeat (GAP + 2) step();
    check("to_idle_pend", PENDING, 0);
    OVR_CLR = 1'b1;
    step();
    OVR_CLR = 1'b0;
    check("to_clr", TIMEOUT, 0);

    // Service order with every button held pending
    RST = 1'b1;
    step();
    RST = 1'b0;
    BTN_PULSE = 4'hF;
    for (int n = 0; n < 5; n++) begin
`ifdef BTN_ARB_ROUND_ROBIN_EN
      exp_id = n % N;
`else
      exp_id = 0;
`endif
      wait_intr("ord", r1);
      check("order_id", BTN_ID, exp_id);
      step();
      ack();
    end
    BTN_PULSE = '0;
    RST = 1'b1;
    step();
    RST = 1'b0;

    // Reset in the middle of a service with another press pending
    BTN_PULSE = 4'b0010;
    step();
    BTN_PULSE = '0;
    wait_intr("rm", r1);
    step();
    BTN_PULSE = 4'b1000;
    step();
    BTN_PULSE = '0;
    check("rm_pend_before", PENDING, 4'b1000);
    check("rm_id_before", BTN_ID, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rm_intr", INTR, 0);
    check("rm_pend", PENDING, 0);
    check("rm_ovr", OVERRUN, 0);
    check("rm_id", BTN_ID, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) BTN_PULSE[b] = ($urandom_range(0, 9) == 0);
      INTR_ACK = ($urandom_range(0, 4) == 0);
      OVR_CLR  = ($urandom_range(0, 39) == 0);
      RST      = ($urandom_range(0, 699) == 0);
      step();
    end
    BTN_PULSE = '0;
    INTR_ACK  = 1'b0;
    OVR_CLR   = 1'b0;
    RST       = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
